evt_timestamp_capture: RTL and testbench
========================================

# evt_timestamp_capture

Downstream consumer of the 16-bit loadable up-counter. It extends the counter to a wider timebase by counting wraps, and time-stamps rising edges of an asynchronous event input with {wrap count, counter value}. Stamps are buffered in a small first-word-fall-through FIFO that a host drains with a read strobe.

## Interface
- `HI_W`, 8: width of wrap (overflow) extension counter.
- `DEPTH`, 4: FIFO depth; power of two, ≥ 2.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cnt_in`  in  16  counter value (counter `dout`).
- `cout_in`  in  1  counter terminal flag, high when counter = 16'hFFFF.
- `en_in`  in  1  counter enable, same signal that drives the counter.
- `evt`  in  1  asynchronous event input.
- `rd`  in  1  read strobe; pops head entry when `empty` = 0.
- `clr_ovr`  in  1  clears sticky overrun flag.
- `ts_out`  out  HI_W+16  head entry {hi, cnt}; 0 when empty.
- `empty`  out  1  FIFO empty.
- `full`  out  1  FIFO holds DEPTH entries.
- `level`  out  log2(DEPTH)+1  entry count, 0..DEPTH.
- `ovr`  out  1  sticky: an event was dropped because the FIFO was full.

## Operation
- **Wrap counter `hi`:** increments by 1 on each edge where `cout_in` = 1 and `en_in` = 1. This is the edge on which the counter goes FFFF→0000. It wraps modulo 2^HI_W silently.
- **Event path:**
  - `evt` passes through a two-flop synchronizer (s1, s2), then a history flop s3.
  - `cap` = s2 & ~s3.
  - One capture occurs per rising edge of `evt`. Pulses shorter than one clock period may be missed; this is not an error.
- **Capture:** on an edge with `cap` = 1, the word {`hi`, `cnt_in`} is written, using the values present in that cycle (pre-increment).
  - If capture coincides with a wrap, the stored word is {old hi, 16'hFFFF}.
- **FIFO:**
  - Circular buffer with read/write pointers and a level counter.
  - `ts_out` = mem[rptr] combinationally while not empty.
  - `rd` while empty is ignored; no pointer move, no error.
- **Simultaneous events:**
  - Capture and `rd`, FIFO not empty and not full: write and pop; `level` unchanged.
  - Capture and `rd`, FIFO full: pop and write both happen; no drop, `ovr` unchanged.
  - Capture and `rd`, FIFO empty: write only; `rd` ignored.
  - Capture, FIFO full, no `rd`: word dropped, `ovr` ← 1.
  - `clr_ovr` and a drop in the same cycle: `ovr` stays 1.
- **`ovr` clearing:** cleared only by `clr_ovr`; otherwise holds.
- **Reset (any time, including mid-operation):**
  - `hi`, pointers, `level`, `ovr`, s1/s2/s3 go to 0; `empty` = 1, `full` = 0, `ts_out` = 0.
  - FIFO contents are discarded.
  - If `evt` is high when reset deasserts, exactly one capture results (s3 was 0).

## Timing
- Event latency: `evt` rising before edge E is sampled into s1 at E, s2 at E+1. `cap` is high during the cycle after E+1, so the capture edge is E+2. The stamp is visible on `ts_out` after E+2 (if it is the only entry) with `empty` = 0.
- Pop: `ts_out` advances to the next entry immediately after the edge on which `rd` = 1.
- `level`, `full`, `empty`, `ovr` are registered or derived from registered state; they update on the same edge as the write/pop.
- `hi` updates on the wrap edge; a capture one cycle later sees the new `hi` and `cnt_in` = 0000.

## Test plan
- **Reset values:** assert `rst` = 0 with `evt` = 0 → `ts_out` = 0, `empty` = 1, `full` = 0, `level` = 0, `ovr` = 0.
- **Single event:** `cnt_in` free-running from 16'h0100 with `en_in` = 1. Raise `evt` just before edge E → entry {8'h00, 16'h0102} (`cnt_in` value at E+2); `empty` falls after E+2; `rd` pulse → `empty` = 1.
- **Wrap boundary:**
  - Drive 16'hFFFF with `cout_in` = 1, `en_in` = 1 and time a capture on that edge → stored {00, FFFF}.
  - Capture one cycle later → {01, 0000}.
  - With `en_in` = 0 and `cout_in` = 1, `hi` stays unchanged.
- **Overrun:** 5 events, no `rd`, `DEPTH` = 4 → `full` = 1, `level` = 4, `ovr` = 1. The fifth stamp is absent after draining 4; `clr_ovr` → `ovr` = 0.
- **Full with simultaneous `rd` and capture:** FIFO holds 4, `rd` and capture on the same edge → `level` stays 4, `ovr` stays 0, new stamp read last.
- **Reset mid-operation:** 3 entries queued, `hi` = 5. Pulse `rst` with `evt` held high → `level` = 0, `hi` = 0; after release, exactly one capture {00, `cnt_in`} occurs at the 3rd edge after release.

Source files
------------

// File: rtl/evt_timestamp_capture_if.sv
// Host/counter bundle for evt_timestamp_capture.
// slave: DUT side (takes counter/event/host strobes, drives FIFO status); master: driver side.
interface evt_timestamp_capture_if #(
    parameter int HI_W  = 8,
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [15:0]      cnt_in;
    logic             cout_in;
    logic             en_in;
    logic             evt;
    logic             rd;
    logic             clr_ovr;
    logic [HI_W+15:0] ts_out;
    logic             empty;
    logic             full;
    logic [LW-1:0]    level;
    logic             ovr;

    modport master (
        output cnt_in, cout_in, en_in, evt, rd, clr_ovr,
        input  ts_out, empty, full, level, ovr
    );

    modport slave (
        input  cnt_in, cout_in, en_in, evt, rd, clr_ovr,
        output ts_out, empty, full, level, ovr
    );
endinterface

// File: rtl/evt_timestamp_capture.sv
// Time-stamps rising edges of async evt with {wrap count, counter} into a FWFT FIFO.
// Ports: clk, rst (async active-low), bus (slave): counter inputs, evt, rd/clr_ovr, ts_out/status.
module evt_timestamp_capture #(
    parameter int HI_W  = 8,
    parameter int DEPTH = 4
) (
    input logic                    clk,
    input logic                    rst,
    evt_timestamp_capture_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = HI_W + 16;

    logic          s1_q, s2_q, s3_q;
    logic [HI_W-1:0] hi_q, hi_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ovr_q, ovr_d;
    logic [TW-1:0] mem_q [DEPTH];
    logic [TW-1:0] mem_d [DEPTH];

    logic cap, empty, full, pop, push, drop;

    always_comb begin
        empty = (level_q == '0);
        full  = (level_q == LW'(DEPTH));
        cap   = s2_q & ~s3_q;
        pop   = bus.rd & ~empty;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push  = cap & (~full | pop);
        drop  = cap & full & ~pop;

        hi_d    = hi_q + HI_W'(bus.cout_in & bus.en_in);
        wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
        level_d = level_q + LW'(push) - LW'(pop);
        // A drop wins over a simultaneous clear.
        ovr_d   = drop | (ovr_q & ~bus.clr_ovr);

        mem_d = mem_q;
        if (push) begin
            mem_d[wptr_q] = {hi_q, bus.cnt_in};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            hi_q    <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ovr_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            s1_q    <= bus.evt;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            hi_q    <= hi_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            ovr_q   <= ovr_d;
            mem_q   <= mem_d;
        end
    end

    always_comb begin
        bus.ts_out = empty ? '0 : mem_q[rptr_q];
        bus.empty  = empty;
        bus.full   = full;
        bus.level  = level_q;
        bus.ovr    = ovr_q;
    end
endmodule

// File: tb/tb_evt_timestamp_capture.sv
// Directed bench for evt_timestamp_capture; the bench models the 16-bit counter.
// Ports: none.
module tb_evt_timestamp_capture;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    evt_timestamp_capture_if #(.HI_W(8), .DEPTH(4)) bus ();

    evt_timestamp_capture #(.HI_W(8), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock; inputs change 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.en_in) bus.cnt_in = bus.cnt_in + 16'd1;
        bus.cout_in = (bus.cnt_in == 16'hFFFF);
    endtask

    task automatic set_cnt(input logic [15:0] v);
        bus.cnt_in  = v;
        bus.cout_in = (v == 16'hFFFF);
    endtask

    // One-cycle evt pulse; capture lands on the 3rd edge (cnt start+2).
    task automatic pulse(input logic rd_at_cap);
        bus.evt = 1'b1;
        tick();
        bus.evt = 1'b0;
        tick();
        bus.rd = rd_at_cap;
        tick();
        bus.rd = 1'b0;
        tick();
    endtask

    task automatic pop();
        bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0;
    endtask

    initial begin
        bus.cnt_in  = 16'h0000;
        bus.cout_in = 1'b0;
        bus.en_in   = 1'b0;
        bus.evt     = 1'b0;
        bus.rd      = 1'b0;
        bus.clr_ovr = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        check("rst_ts", 32'(bus.ts_out), 32'h0);
        check("rst_empty", 32'(bus.empty), 32'h1);
        check("rst_full", 32'(bus.full), 32'h0);
        check("rst_level", 32'(bus.level), 32'h0);
        check("rst_ovr", 32'(bus.ovr), 32'h0);
        rst = 1'b1;
        tick();

        pop();
        check("rd_empty_level", 32'(bus.level), 32'h0);
        check("rd_empty_empty", 32'(bus.empty), 32'h1);

        // Single event
        bus.en_in = 1'b1;
        set_cnt(16'h0100);
        bus.evt = 1'b1;
        tick();
        tick();
        check("single_lat_empty", 32'(bus.empty), 32'h1);
        tick();
        check("single_empty", 32'(bus.empty), 32'h0);
        check("single_ts", 32'(bus.ts_out), 32'h000102);
        check("single_level", 32'(bus.level), 32'h1);
        bus.evt = 1'b0;
        tick();
        tick();
        pop();
        check("single_pop_empty", 32'(bus.empty), 32'h1);
        check("single_pop_ts", 32'(bus.ts_out), 32'h0);

        // Capture one cycle after the wrap sees new hi
        set_cnt(16'hFFFE);
        pulse(1'b0);
        check("wrap_after", 32'(bus.ts_out), 32'h010000);
        pop();
        // Capture on the wrap edge keeps old hi
        set_cnt(16'hFFFD);
        pulse(1'b0);
        check("wrap_on", 32'(bus.ts_out), 32'h01FFFF);
        pop();
        // cout without enable must not bump hi
        bus.en_in = 1'b0;
        set_cnt(16'hFFFF);
        tick();
        tick();
        tick();
        pulse(1'b0);
        check("wrap_noen", 32'(bus.ts_out), 32'h02FFFF);
        pop();
        bus.en_in = 1'b1;
        set_cnt(16'h0010);
        pulse(1'b0);
        check("wrap_noen_next", 32'(bus.ts_out), 32'h020012);
        pop();
        check("wrap_drained", 32'(bus.empty), 32'h1);

        // Overrun
        set_cnt(16'h0200);
        for (int i = 0; i < 5; i++) pulse(1'b0);
        check("ovr_full", 32'(bus.full), 32'h1);
        check("ovr_level", 32'(bus.level), 32'h4);
        check("ovr_flag", 32'(bus.ovr), 32'h1);
        check("ovr_d0", 32'(bus.ts_out), 32'h020202);
        pop();
        check("ovr_d1", 32'(bus.ts_out), 32'h020206);
        pop();
        check("ovr_d2", 32'(bus.ts_out), 32'h02020A);
        pop();
        check("ovr_d3", 32'(bus.ts_out), 32'h02020E);
        pop();
        check("ovr_drained", 32'(bus.empty), 32'h1);
        check("ovr_drained_ts", 32'(bus.ts_out), 32'h0);
        check("ovr_sticky", 32'(bus.ovr), 32'h1);
        bus.clr_ovr = 1'b1;
        tick();
        bus.clr_ovr = 1'b0;
        check("ovr_clr", 32'(bus.ovr), 32'h0);

        // Full with simultaneous rd and capture
        set_cnt(16'h0300);
        for (int i = 0; i < 4; i++) pulse(1'b0);
        check("fs_pre_level", 32'(bus.level), 32'h4);
        pulse(1'b1);
        check("fs_level", 32'(bus.level), 32'h4);
        check("fs_ovr", 32'(bus.ovr), 32'h0);
        check("fs_d0", 32'(bus.ts_out), 32'h020306);
        pop();
        check("fs_d1", 32'(bus.ts_out), 32'h02030A);
        pop();
        check("fs_d2", 32'(bus.ts_out), 32'h02030E);
        pop();
        check("fs_d3", 32'(bus.ts_out), 32'h020312);
        pop();
        check("fs_drained", 32'(bus.empty), 32'h1);

        // Bring hi to 5, queue three entries
        for (int i = 0; i < 3; i++) begin
            set_cnt(16'hFFFF);
            tick();
        end
        bus.en_in = 1'b0;
        set_cnt(16'h0400);
        for (int i = 0; i < 3; i++) pulse(1'b0);
        check("mid_level", 32'(bus.level), 32'h3);
        check("mid_ts", 32'(bus.ts_out), 32'h050400);

        // Reset mid-operation with evt held high
        bus.evt = 1'b1;
        rst = 1'b0;
        #1;
        check("mid_rst_level", 32'(bus.level), 32'h0);
        check("mid_rst_empty", 32'(bus.empty), 32'h1);
        check("mid_rst_ts", 32'(bus.ts_out), 32'h0);
        tick();
        bus.en_in = 1'b1;
        set_cnt(16'h0500);
        rst = 1'b1;
        tick();
        tick();
        check("rel_lat_empty", 32'(bus.empty), 32'h1);
        tick();
        check("rel_level", 32'(bus.level), 32'h1);
        check("rel_ts", 32'(bus.ts_out), 32'h000502);
        tick();
        tick();
        tick();
        check("rel_once", 32'(bus.level), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
